// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes a MIPS instruction into ALU control and operands
// and holds them in a one-entry valid/ready register with stall and flush.
module alu_issue_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] bus_a,
  output logic [31:0] bus_b,
  output logic        is_branch,
  output logic        branch_ne,
  output logic        illegal
);

  localparam logic [3:0] CtrlAnd  = 4'b0000;
  localparam logic [3:0] CtrlOr   = 4'b0001;
  localparam logic [3:0] CtrlAdd  = 4'b0010;
  localparam logic [3:0] CtrlSll  = 4'b0011;
  localparam logic [3:0] CtrlSrl  = 4'b0100;
  localparam logic [3:0] CtrlSub  = 4'b0110;
  localparam logic [3:0] CtrlSlt  = 4'b0111;
  localparam logic [3:0] CtrlAddu = 4'b1000;
  localparam logic [3:0] CtrlSubu = 4'b1001;
  localparam logic [3:0] CtrlXor  = 4'b1010;
  localparam logic [3:0] CtrlSltu = 4'b1011;
  localparam logic [3:0] CtrlNor  = 4'b1100;
  localparam logic [3:0] CtrlSra  = 4'b1101;
  localparam logic [3:0] CtrlLui  = 4'b1110;
  localparam logic [3:0] CtrlIll  = 4'b1111;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic        unused_instr;

  assign opcode       = instr[31:26];
  assign funct        = instr[5:0];
  assign shamt        = instr[10:6];
  assign imm          = instr[15:0];
  assign imm_sext     = {{16{imm[15]}}, imm};
  assign imm_zext     = {16'b0, imm};
  assign unused_instr = ^instr[25:16];

  logic [3:0]  dec_ctrl;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic        dec_branch;
  logic        dec_ne;
  logic        dec_illegal;

  // Illegal is inferred from the control code staying at its reserved value.
  always_comb begin
    dec_ctrl    = CtrlIll;
    dec_a       = rs_data;
    dec_b       = rt_data;
    dec_branch  = 1'b0;
    dec_ne      = 1'b0;
    unique case (opcode)
      6'h00: begin
        case (funct)
          6'h00: begin dec_ctrl = CtrlSll; dec_a = {27'b0, shamt}; end
          6'h02: begin dec_ctrl = CtrlSrl; dec_a = {27'b0, shamt}; end
          6'h03: begin dec_ctrl = CtrlSra; dec_a = {27'b0, shamt}; end
          6'h04: begin dec_ctrl = CtrlSll; dec_a = {27'b0, rs_data[4:0]}; end
          6'h06: begin dec_ctrl = CtrlSrl; dec_a = {27'b0, rs_data[4:0]}; end
          6'h07: begin dec_ctrl = CtrlSra; dec_a = {27'b0, rs_data[4:0]}; end
          6'h20: dec_ctrl = CtrlAdd;
          6'h21: dec_ctrl = CtrlAddu;
          6'h22: dec_ctrl = CtrlSub;
          6'h23: dec_ctrl = CtrlSubu;
          6'h24: dec_ctrl = CtrlAnd;
          6'h25: dec_ctrl = CtrlOr;
          6'h26: dec_ctrl = CtrlXor;
          6'h27: dec_ctrl = CtrlNor;
          6'h2A: dec_ctrl = CtrlSlt;
          6'h2B: dec_ctrl = CtrlSltu;
          default: dec_ctrl = CtrlIll;
        endcase
      end
      6'h04: begin dec_ctrl = CtrlSub; dec_branch = 1'b1; end
      6'h05: begin dec_ctrl = CtrlSub; dec_branch = 1'b1; dec_ne = 1'b1; end
      6'h08: begin dec_ctrl = CtrlAdd;  dec_b = imm_sext; end
      6'h09: begin dec_ctrl = CtrlAddu; dec_b = imm_sext; end
      6'h0A: begin dec_ctrl = CtrlSlt;  dec_b = imm_sext; end
      6'h0B: begin dec_ctrl = CtrlSltu; dec_b = imm_sext; end
      6'h0C: begin dec_ctrl = CtrlAnd;  dec_b = imm_zext; end
      6'h0D: begin dec_ctrl = CtrlOr;   dec_b = imm_zext; end
      6'h0E: begin dec_ctrl = CtrlXor;  dec_b = imm_zext; end
      6'h0F: begin dec_ctrl = CtrlLui;  dec_a = 32'b0; dec_b = imm_zext; end
      6'h23: begin dec_ctrl = CtrlAdd;  dec_b = imm_sext; end
      6'h2B: begin dec_ctrl = CtrlAdd;  dec_b = imm_sext; end
      default: dec_ctrl = CtrlIll;
    endcase
    dec_illegal = (dec_ctrl == CtrlIll);
    if (dec_illegal) begin
      dec_a = 32'b0;
      dec_b = 32'b0;
    end
  end

  logic        out_valid_q, out_valid_d;
  logic [3:0]  alu_ctrl_q, alu_ctrl_d;
  logic [31:0] bus_a_q, bus_a_d;
  logic [31:0] bus_b_q, bus_b_d;
  logic        is_branch_q, is_branch_d;
  logic        branch_ne_q, branch_ne_d;
  logic        illegal_q, illegal_d;
  logic        load;

  assign in_ready = !out_valid_q || out_ready;
  assign load     = in_valid && in_ready && !flush;

  always_comb begin
    out_valid_d = out_valid_q;
    alu_ctrl_d  = alu_ctrl_q;
    bus_a_d     = bus_a_q;
    bus_b_d     = bus_b_q;
    is_branch_d = is_branch_q;
    branch_ne_d = branch_ne_q;
    illegal_d   = illegal_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (load) begin
      out_valid_d = 1'b1;
      alu_ctrl_d  = dec_ctrl;
      bus_a_d     = dec_a;
      bus_b_d     = dec_b;
      is_branch_d = dec_branch;
      branch_ne_d = dec_ne;
      illegal_d   = dec_illegal;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      alu_ctrl_q  <= 4'b0;
      bus_a_q     <= 32'b0;
      bus_b_q     <= 32'b0;
      is_branch_q <= 1'b0;
      branch_ne_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      alu_ctrl_q  <= alu_ctrl_d;
      bus_a_q     <= bus_a_d;
      bus_b_q     <= bus_b_d;
      is_branch_q <= is_branch_d;
      branch_ne_q <= branch_ne_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign alu_ctrl  = alu_ctrl_q;
  assign bus_a     = bus_a_q;
  assign bus_b     = bus_b_q;
  assign is_branch = is_branch_q;
  assign branch_ne = branch_ne_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed instructions with hand-computed
// expected payloads, plus direct checks of stall, flush and asynchronous reset.
module tb_alu_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] bus_a;
  logic [31:0] bus_b;
  logic        is_branch;
  logic        branch_ne;
  logic        illegal;

  alu_issue_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_ctrl  (alu_ctrl),
    .bus_a     (bus_a),
    .bus_b     (bus_b),
    .is_branch (is_branch),
    .branch_ne (branch_ne),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic        br;
    logic        ne;
    logic        ill;
  } pkt_t;

  pkt_t exp_q[$];
  int   n_checks;
  int   n_pass;

  function automatic pkt_t mk(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                              input logic br, input logic ne, input logic ill);
    pkt_t p;
    p.ctrl = c; p.a = a; p.b = b; p.br = br; p.ne = ne; p.ill = ill;
    return p;
  endfunction

  function automatic pkt_t cur();
    return mk(alu_ctrl, bus_a, bus_b, is_branch, branch_ne, illegal);
  endfunction

  task automatic chk(input string name, input logic [72:0] act, input logic [72:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  // Monitor: every accepted output beat must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 73'(cur()), 73'h0);
        if (cur() == pkt_t'(0)) begin
          n_pass--;
          $display("FAIL unexpected_beat: got a valid beat, required none");
        end
      end else begin
        chk("beat", 73'(cur()), 73'(exp_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] rs,
                       input logic [31:0] rt);
    in_valid = v; instr = ins; rs_data = rs; rt_data = rt;
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    rst_n = 1'b1; in_valid = 1'b0; instr = '0; rs_data = '0; rt_data = '0;
    flush = 1'b0; out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_outputs", {72'(cur()), out_valid}, 73'h0);
    chk("reset_in_ready", 73'(in_ready), 73'h1);
    #9 rst_n = 1'b1;

    // ADDI then back-to-back SRAV / SRA
    step();
    exp_q.push_back(mk(4'b0010, 32'd5, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0));
    drive(1'b1, 32'h2008_FFFF, 32'd5, 32'h0);
    step();
    chk("addi_latency", 73'(out_valid), 73'h1);
    exp_q.push_back(mk(4'b1101, 32'h3, 32'hABCD_0000, 1'b0, 1'b0, 1'b0));
    drive(1'b1, 32'h0000_0007, 32'h0000_0123, 32'hABCD_0000);
    step();
    exp_q.push_back(mk(4'b1101, 32'h7, 32'h8000_0001, 1'b0, 1'b0, 1'b0));
    drive(1'b1, 32'h0000_01C3, 32'hFFFF_FFFF, 32'h8000_0001);
    step();
    chk("no_bubble", 73'({out_valid, in_ready}), 73'h3);
    // ORI, LUI
    exp_q.push_back(mk(4'b0001, 32'h1111_2222, 32'h0000_8000, 1'b0, 1'b0, 1'b0));
    drive(1'b1, 32'h3508_8000, 32'h1111_2222, 32'h0);
    step();
    exp_q.push_back(mk(4'b1110, 32'h0, 32'h0000_1234, 1'b0, 1'b0, 1'b0));
    drive(1'b1, 32'h3C08_1234, 32'hDEAD_BEEF, 32'h5);
    step();
    // BNE, then stall 3 cycles with a new instruction waiting
    drive(1'b1, 32'h1509_0003, 32'd7, 32'd7);
    step();
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_0021, 32'h1, 32'h2);
    #1;
    chk("bne_loaded", {72'(cur()), out_valid},
        {72'(mk(4'b0110, 32'd7, 32'd7, 1'b1, 1'b1, 1'b0)), 1'b1});
    chk("stall_in_ready", 73'(in_ready), 73'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_hold", {72'(cur()), out_valid, in_ready},
          {72'(mk(4'b0110, 32'd7, 32'd7, 1'b1, 1'b1, 1'b0)), 2'b10});
    end
    // Flush with the waiting instruction still offered
    flush = 1'b1;
    step();
    chk("flush_clears", 73'(out_valid), 73'h0);
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    out_ready = 1'b1;
    step();
    chk("flush_discards", 73'(out_valid), 73'h0);

    // R-type / I-type stream with an illegal funct
    exp_q.push_back(mk(4'b1001, 32'h10, 32'h3, 1'b0, 1'b0, 1'b0));
    drive(1'b1, 32'h0000_0023, 32'h10, 32'h3);
    step();
    exp_q.push_back(mk(4'b0111, 32'hFFFF_FFFE, 32'h1, 1'b0, 1'b0, 1'b0));
    drive(1'b1, 32'h0000_002A, 32'hFFFF_FFFE, 32'h1);
    step();
    exp_q.push_back(mk(4'b1100, 32'hF0F0_0000, 32'h0F0F_0000, 1'b0, 1'b0, 1'b0));
    drive(1'b1, 32'h0000_0027, 32'hF0F0_0000, 32'h0F0F_0000);
    step();
    exp_q.push_back(mk(4'b0010, 32'h1000, 32'hFFFF_8000, 1'b0, 1'b0, 1'b0));
    drive(1'b1, 32'h8C00_8000, 32'h1000, 32'h9);
    step();
    exp_q.push_back(mk(4'b1011, 32'h42, 32'h0000_7FFF, 1'b0, 1'b0, 1'b0));
    drive(1'b1, 32'h2C00_7FFF, 32'h42, 32'h9);
    step();
    exp_q.push_back(mk(4'b1010, 32'h55, 32'h0000_F0F0, 1'b0, 1'b0, 1'b0));
    drive(1'b1, 32'h3800_F0F0, 32'h55, 32'h9);
    step();
    exp_q.push_back(mk(4'b1111, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1));
    drive(1'b1, 32'h0000_0001, 32'h77, 32'h88);
    step();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
    chk("drained", 73'(exp_q.size()), 73'h0);

    // Illegal opcode held under stall, then asynchronous reset mid-cycle
    out_ready = 1'b0;
    drive(1'b1, 32'hFC00_0000, 32'h1234, 32'h5678);
    step();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    chk("illegal_op", {72'(cur()), out_valid},
        {72'(mk(4'b1111, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1)), 1'b1});
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", {72'(cur()), out_valid}, 73'h0);
    chk("async_reset_ready", 73'(in_ready), 73'h1);
    #3 rst_n = 1'b1;
    step();
    chk("post_reset_idle", 73'({out_valid, in_ready}), 73'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode-and-issue stage for the ALU: it receives a decoded MIPS instruction word and register operands from the ID stage. It produces the registered `ALUCtrl`, `BusA` and `BusB` values the ALU consumes, plus branch qualifiers for interpreting the ALU `Zero` flag. It forms the ID/EX boundary and uses a one-entry valid/ready pipeline register with stall and flush.

## Interface
- No parameters. Data width is fixed at 32 and `ALUCtrl` is fixed at 4 bits.
- `clk` input 1: single clock. All state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: ID stage presents an instruction.
- `in_ready` output 1: stage can accept this cycle.
- `instr` input 32: instruction word. Fields used: opcode[31:26], shamt[10:6], funct[5:0], imm[15:0].
- `rs_data` input 32: rs register value.
- `rt_data` input 32: rt register value.
- `flush` input 1: squash the held entry and the incoming instruction.
- `out_valid` output 1: registered outputs are valid.
- `out_ready` input 1: EX stage consumes this cycle.
- `alu_ctrl` output 4: ALU operation code.
- `bus_a` output 32: ALU operand A.
- `bus_b` output 32: ALU operand B.
- `is_branch` output 1: the result's `Zero` flag decides a branch.
- `branch_ne` output 1: branch taken when `Zero` = 0 (BNE). When low, the branch is taken on `Zero` = 1 (BEQ).
- `illegal` output 1: unrecognised opcode/funct.

## Operation
- `alu_ctrl` encodings: AND 0000, OR 0001, ADD 0010, SLL 0011, SRL 0100, SUB 0110, SLT 0111, ADDU 1000, SUBU 1001, XOR 1010, SLTU 1011, NOR 1100, SRA 1101, LUI 1110. Illegal instructions use 1111.
- R-type (opcode 0x00), `bus_b` = `rt_data`:
  - funct 0x00/0x02/0x03 → SLL/SRL/SRA, with `bus_a` = {27'b0, shamt}.
  - funct 0x04/0x06/0x07 → SLL/SRL/SRA, with `bus_a` = {27'b0, rs_data[4:0]}.
  - 0x20 ADD, 0x21 ADDU, 0x22 SUB, 0x23 SUBU, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT, 0x2B SLTU, each with `bus_a` = `rs_data`.
- I-type, `bus_a` = `rs_data`, `bus_b` = immediate:
  - Sign-extended immediate: 0x08 ADD, 0x09 ADDU, 0x0A SLT, 0x0B SLTU, 0x23 LW → ADD, 0x2B SW → ADD.
  - Zero-extended immediate: 0x0C AND, 0x0D OR, 0x0E XOR.
  - 0x0F LUI: `bus_b` = {16'b0, imm}, `bus_a` = 0. The ALU performs the shift.
- Branches: 0x04 BEQ and 0x05 BNE → SUB with `bus_a` = `rs_data`, `bus_b` = `rt_data`, `is_branch` = 1. `branch_ne` = 1 only for 0x05.
- Any other opcode/funct: `alu_ctrl` = 1111, `bus_a` = `bus_b` = 0, `illegal` = 1. The entry still flows as valid.
- `is_branch`, `branch_ne` and `illegal` are 0 for every instruction not listed for them.
- Pipeline register:
  - `in_ready` = !`out_valid` | `out_ready`. This is combinational and has no dependence on `in_valid`.
  - Load when `in_valid` & `in_ready`: all payload outputs take the decoded values and `out_valid` ← 1.
  - Drain without new input (`out_valid` & `out_ready` & !`in_valid`): `out_valid` ← 0. The payload holds its last value.
  - Stall (`out_valid` & !`out_ready`): all outputs hold and the input is not accepted.
  - Flush (highest priority): `out_valid` ← 0, no load, and the incoming instruction is discarded regardless of `in_valid`/`out_ready`.
  - Simultaneous drain and load: the new entry replaces the old one in the same edge. There are no bubbles at full throughput.

## Timing
- Latency: 1 cycle from accepted input to `out_valid`. Throughput: 1 instruction per cycle.
- Reset (async assert, sync-safe deassert to first edge) sets: `out_valid` 0, `alu_ctrl` 0000, `bus_a` 0, `bus_b` 0, `is_branch` 0, `branch_ne` 0, `illegal` 0.
- Reset mid-stall discards the held entry. `in_ready` reads 1 immediately after reset.
- All outputs except `in_ready` are registered.
- There is no path from `in_valid`, `instr` or data inputs to any output in the same cycle.

## Test plan
- ADDI: `instr` 0x2008FFFF, `rs_data` 5, `out_ready` 1 → next cycle `alu_ctrl` 0010, `bus_a` 5, `bus_b` 0xFFFFFFFF, `out_valid` 1.
- SRAV then SRA back-to-back:
  - SRAV with `rs_data` 0x00000123 → `bus_a` 0x00000003, `alu_ctrl` 1101.
  - Next cycle, SRA with shamt 7 → `bus_a` 7.
  - There is no bubble between the two.
- ORI 0x3508_8000 → `alu_ctrl` 0001, `bus_b` 0x00008000 (zero-extended). LUI 0x3C08_1234 → `alu_ctrl` 1110, `bus_a` 0, `bus_b` 0x00001234.
- BNE 0x1509_0003 with `rs_data` 7, `rt_data` 7 → `alu_ctrl` 0110, `is_branch` 1, `branch_ne` 1. A stall of 3 cycles (`out_ready` 0) holds all outputs and keeps `in_ready` 0.
- Flush while holding a stalled entry with `in_valid` 1 → `out_valid` 0 next cycle and the incoming instruction does not appear.
- Illegal: opcode 0x3F → `alu_ctrl` 1111, `illegal` 1. Asserting `rst_n` = 0 mid-cycle clears `out_valid` and all outputs immediately, without a clock edge.
